instruction_memory_loader: RTL and testbench
============================================

# instruction_memory_loader

Parametrised byte-addressed instruction memory with a built-in byte-stream loader FSM, a stepped fetch port and a registered debug read port. Sits between the debug unit (UART byte stream in, program/readback) and the IF stage (PC in, instruction out). It replaces the word-at-a-time debug write with an assembled byte loader, and moves fetch to a single clock edge with a valid strobe.

## Interface
Parameters:
- INST_BITS, 32, instruction width; multiple of BYTE_BITS
- BYTE_BITS, 8, width of one memory cell and of a loader byte
- CELLS, 1024, memory depth in bytes; power of two, multiple of INST_BITS/BYTE_BITS

Derived: BPI = INST_BITS/BYTE_BITS (bytes per instruction), ADDR_BITS = $clog2(CELLS).

Ports:
- i_clk  in  1  single clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_step  in  1  fetch enable for this cycle
- i_addr  in  INST_BITS  fetch byte address (PC)
- o_inst  out  INST_BITS  fetched instruction, byte at lowest address in MSBs
- o_inst_valid  out  1  one-cycle strobe: o_inst updated
- i_ld_start  in  1  start a load session; write pointer cleared to 0
- i_ld_end  in  1  end session; flush partial word
- i_ld_byte  in  BYTE_BITS  loader data byte
- i_ld_valid  in  1  byte present
- o_ld_ready  out  1  loader accepts a byte this cycle
- o_ld_busy  out  1  FSM not in IDLE
- o_ld_full  out  1  write pointer reached CELLS
- o_ld_count  out  ADDR_BITS+1  bytes written to memory this session
- i_dbg_addr  in  INST_BITS  debug readback byte address
- o_dbg_data  out  INST_BITS  registered readback word

## Operation
- Memory: CELLS x BYTE_BITS array, not reset. All byte indices are (addr + k) mod CELLS, k = 0..BPI-1; address bits above ADDR_BITS ignored.
- FSM states IDLE, LOAD, FLUSH.
  - IDLE: i_ld_start -> LOAD; pointer, byte counter, shift register, o_ld_count, o_ld_full cleared.
  - LOAD: o_ld_ready = 1 unless o_ld_full. Accepted byte (i_ld_valid & o_ld_ready) shifts into assembly register. On the BPI-th byte the full word (register + incoming byte) is written at the pointer the same edge; pointer += BPI, o_ld_count += BPI. If pointer becomes CELLS: o_ld_full = 1, -> IDLE.
  - LOAD + i_ld_end: byte counter 0 -> IDLE; else -> FLUSH. A byte accepted in the same cycle as i_ld_end is included.
  - FLUSH: write partial word left-justified, remaining low bytes zero; o_ld_count += bytes held; -> IDLE. o_ld_ready = 0.
  - i_ld_start while busy: ignored.
- Fetch: in IDLE, i_step = 1 -> o_inst <= bytes addr..addr+BPI-1 concatenated, o_inst_valid <= 1. i_step = 0 or FSM busy -> o_inst holds, o_inst_valid <= 0.
- Debug read: every cycle o_dbg_data <= word at i_dbg_addr (wrapping as fetch). Same-cycle loader write to those bytes returns old data.
- o_ld_full holds until next i_ld_start.

## Timing
- Reset (async assert, sync release): FSM IDLE; o_inst = 0, o_inst_valid = 0, o_ld_ready = 0, o_ld_busy = 0, o_ld_full = 0, o_ld_count = 0, o_dbg_data = 0; pointer/counter/shift register 0. Reset mid-load aborts session; bytes already written stay.
- Fetch latency 1 cycle: i_step sampled at edge N, o_inst/o_inst_valid valid after edge N.
- Loader: byte accepted at edge N becomes visible on o_dbg_data after edge N+1 (write at N, registered read at N+1). Throughput 1 byte/cycle, no bubble between words.
- FLUSH: exactly 1 cycle; o_ld_busy falls the cycle after.
- o_ld_ready combinational from state and o_ld_full only (never from i_ld_valid).

## Configuration
- INST_MEM_FETCH_ERR_EN defined: adds output o_fetch_err (1 bit, reset 0), updated with o_inst on each fetch; set when i_addr[$clog2(BPI)-1:0] != 0 or i_addr >= CELLS; on error o_inst <= 0 and o_inst_valid still pulses.
- Undefined: port absent; misaligned/out-of-range addresses silently truncated and wrapped.

## Test plan
- Reset, i_ld_start, stream 8 bytes 01..08, i_ld_end -> o_ld_count = 8, no FLUSH; fetch addr 0 -> 0x01020304, addr 4 -> 0x05060708, o_inst_valid one-cycle pulses.
- Stream 5 bytes AA BB CC DD EE then i_ld_end -> FLUSH one cycle, word at 4 = 0xEE000000, o_ld_count = 5.
- CELLS = 16: stream 20 bytes -> o_ld_full after byte 16, o_ld_ready low, FSM IDLE, bytes 17..20 not written.
- Fetch addr 14 with CELLS = 16 -> bytes 14,15,0,1 (macro off); with INST_MEM_FETCH_ERR_EN -> o_fetch_err = 1, o_inst = 0.
- i_step high during LOAD -> o_inst unchanged, o_inst_valid = 0; debug read at word being written same edge -> old value, new value next cycle.
- Assert i_rst_n low mid-word (2 of 4 bytes) -> all outputs at reset values immediately; next session starts pointer at 0.

Source files
------------

// File: rtl/instruction_memory_loader.sv
`default_nettype none
// ============================================================================
// Module   : instruction_memory_loader
// Purpose  : Byte-addressed instruction memory with a byte-stream loader
//            (IDLE/LOAD/FLUSH), a stepped fetch port and a registered debug
//            read port.
// Ports    : i_clk, i_rst_n (async active-low)
//            fetch  : i_step, i_addr -> o_inst, o_inst_valid [, o_fetch_err]
//            loader : i_ld_start, i_ld_end, i_ld_byte, i_ld_valid ->
//                     o_ld_ready, o_ld_busy, o_ld_full, o_ld_count
//            debug  : i_dbg_addr -> o_dbg_data
// Options  : INST_MEM_FETCH_ERR_EN adds o_fetch_err and zeroes o_inst on a
//            misaligned or out-of-range fetch.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_memory_loader #(
  parameter int INST_BITS = 32,
  parameter int BYTE_BITS = 8,
  parameter int CELLS     = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_step,
  input  logic [INST_BITS-1:0]   i_addr,
  output logic [INST_BITS-1:0]   o_inst,
  output logic                   o_inst_valid,
`ifdef INST_MEM_FETCH_ERR_EN
  output logic                   o_fetch_err,
`endif
  input  logic                   i_ld_start,
  input  logic                   i_ld_end,
  input  logic [BYTE_BITS-1:0]   i_ld_byte,
  input  logic                   i_ld_valid,
  output logic                   o_ld_ready,
  output logic                   o_ld_busy,
  output logic                   o_ld_full,
  output logic [$clog2(CELLS):0] o_ld_count,
  input  logic [INST_BITS-1:0]   i_dbg_addr,
  output logic [INST_BITS-1:0]   o_dbg_data
);

  localparam int BPI       = INST_BITS / BYTE_BITS;
  localparam int ADDR_BITS = $clog2(CELLS);
  localparam int PTR_BITS  = ADDR_BITS + 1;
  localparam int CNT_BITS  = $clog2(BPI + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [PTR_BITS-1:0]  ptr_q, ptr_d;
  logic [CNT_BITS-1:0]  bcnt_q, bcnt_d;
  logic [INST_BITS-1:0] shift_q, shift_d;
  logic [PTR_BITS-1:0]  count_q, count_d;
  logic                 full_q, full_d;
  logic [INST_BITS-1:0] inst_q, inst_d;
  logic                 inst_valid_q, inst_valid_d;
  logic [INST_BITS-1:0] dbg_data_q, dbg_data_d;

  logic [BYTE_BITS-1:0] mem [CELLS];

  logic                 w_accept;
  logic                 w_we;
  logic [INST_BITS-1:0] w_wdata;
  logic [INST_BITS-1:0] w_fetch_word;
  logic [INST_BITS-1:0] w_dbg_word;
  logic                 w_fetch_err;

  // Address bits above ADDR_BITS are intentionally ignored when wrapping.
  logic w_unused_addr;
  assign w_unused_addr = ^{i_addr, i_dbg_addr};

  // --------------------------------------------------------------------------
  // Word reads: byte at the lowest address lands in the MSBs, indices wrap.
  // --------------------------------------------------------------------------
  always_comb begin
    w_fetch_word = '0;
    w_dbg_word   = '0;
    for (int k = 0; k < BPI; k++) begin
      w_fetch_word[INST_BITS-1-k*BYTE_BITS -: BYTE_BITS] =
        mem[i_addr[ADDR_BITS-1:0] + ADDR_BITS'(k)];
      w_dbg_word[INST_BITS-1-k*BYTE_BITS -: BYTE_BITS] =
        mem[i_dbg_addr[ADDR_BITS-1:0] + ADDR_BITS'(k)];
    end
  end

  // Memory array is deliberately not reset; contents survive a reset.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      for (int k = 0; k < BPI; k++) begin
        mem[ptr_q[ADDR_BITS-1:0] + ADDR_BITS'(k)] <=
          w_wdata[INST_BITS-1-k*BYTE_BITS -: BYTE_BITS];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fetch error detection (optional)
  // --------------------------------------------------------------------------
`ifdef INST_MEM_FETCH_ERR_EN
  localparam int LOG_BPI = $clog2(BPI);

  logic w_misaligned;
  logic fetch_err_q, fetch_err_d;

  generate
    if (LOG_BPI > 0) begin : g_align_chk
      assign w_misaligned = |i_addr[LOG_BPI-1:0];
    end else begin : g_no_align_chk
      assign w_misaligned = 1'b0;
    end
  endgenerate

  assign w_fetch_err = w_misaligned || (i_addr >= INST_BITS'(CELLS));
  assign o_fetch_err = fetch_err_q;
`else
  assign w_fetch_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Loader FSM, fetch and debug next-state logic
  // --------------------------------------------------------------------------
  assign o_ld_ready = (state_q == ST_LOAD) && !full_q;
  assign w_accept   = o_ld_ready && i_ld_valid;

  always_comb begin
    int flush_shift;
    flush_shift  = 0;
    state_d      = state_q;
    ptr_d        = ptr_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    count_d      = count_q;
    full_d       = full_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    dbg_data_d   = w_dbg_word;
    w_we         = 1'b0;
    w_wdata      = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_step) begin
          inst_d       = w_fetch_err ? '0 : w_fetch_word;
          inst_valid_d = 1'b1;
        end
        if (i_ld_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          bcnt_d  = '0;
          shift_d = '0;
          count_d = '0;
          full_d  = 1'b0;
        end
      end

      ST_LOAD: begin
        if (w_accept) begin
          // Older bytes drift toward the MSBs as new ones arrive.
          shift_d = (shift_q << BYTE_BITS) | INST_BITS'(i_ld_byte);
          if (bcnt_q == CNT_BITS'(BPI - 1)) begin
            // Last byte of a word: write register + incoming byte this edge.
            w_we    = 1'b1;
            w_wdata = (shift_q << BYTE_BITS) | INST_BITS'(i_ld_byte);
            ptr_d   = ptr_q + PTR_BITS'(BPI);
            count_d = count_q + PTR_BITS'(BPI);
            bcnt_d  = '0;
            shift_d = '0;
            if (ptr_d == PTR_BITS'(CELLS)) begin
              full_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            bcnt_d = bcnt_q + CNT_BITS'(1);
          end
        end
        // bcnt_d already includes a byte accepted alongside i_ld_end.
        if (i_ld_end && (state_d == ST_LOAD)) begin
          state_d = (bcnt_d == '0) ? ST_IDLE : ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        // Held bytes sit in the low end of shift_q; left-justify them.
        flush_shift = (BPI - int'(bcnt_q)) * BYTE_BITS;
        w_we        = 1'b1;
        w_wdata     = shift_q << flush_shift;
        count_d     = count_q + PTR_BITS'(bcnt_q);
        bcnt_d      = '0;
        shift_d     = '0;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef INST_MEM_FETCH_ERR_EN
  always_comb begin
    fetch_err_d = fetch_err_q;
    if ((state_q == ST_IDLE) && i_step) begin
      fetch_err_d = w_fetch_err;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= fetch_err_d;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      dbg_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      count_q      <= count_d;
      full_q       <= full_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      dbg_data_q   <= dbg_data_d;
    end
  end

  assign o_inst       = inst_q;
  assign o_inst_valid = inst_valid_q;
  assign o_ld_busy    = (state_q != ST_IDLE);
  assign o_ld_full    = full_q;
  assign o_ld_count   = count_q;
  assign o_dbg_data   = dbg_data_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_memory_loader
// Purpose  : Scoreboard bench for instruction_memory_loader (CELLS = 16).
//            Stimulus is driven on the falling edge; a reference model pushes
//            the expected post-edge outputs, and a monitor compares them 1 ns
//            after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_memory_loader;

  localparam int IB    = 32;
  localparam int BB    = 8;
  localparam int CELLS = 16;
  localparam int BPI   = IB / BB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_step = 1'b0;
  logic [IB-1:0] i_addr = '0;
  logic [IB-1:0] o_inst;
  logic          o_inst_valid;
`ifdef INST_MEM_FETCH_ERR_EN
  logic          o_fetch_err;
`endif
  logic          i_ld_start = 1'b0;
  logic          i_ld_end = 1'b0;
  logic [BB-1:0] i_ld_byte = '0;
  logic          i_ld_valid = 1'b0;
  logic          o_ld_ready;
  logic          o_ld_busy;
  logic          o_ld_full;
  logic [4:0]    o_ld_count;
  logic [IB-1:0] i_dbg_addr = '0;
  logic [IB-1:0] o_dbg_data;

  always #5 clk = ~clk;

  instruction_memory_loader #(
    .INST_BITS (IB),
    .BYTE_BITS (BB),
    .CELLS     (CELLS)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_step       (i_step),
    .i_addr       (i_addr),
    .o_inst       (o_inst),
    .o_inst_valid (o_inst_valid),
`ifdef INST_MEM_FETCH_ERR_EN
    .o_fetch_err  (o_fetch_err),
`endif
    .i_ld_start   (i_ld_start),
    .i_ld_end     (i_ld_end),
    .i_ld_byte    (i_ld_byte),
    .i_ld_valid   (i_ld_valid),
    .o_ld_ready   (o_ld_ready),
    .o_ld_busy    (o_ld_busy),
    .o_ld_full    (o_ld_full),
    .o_ld_count   (o_ld_count),
    .i_dbg_addr   (i_dbg_addr),
    .o_dbg_data   (o_dbg_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: byte array plus session bookkeeping
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] inst;
    logic        valid;
    logic        err;
    logic        ready;
    logic        busy;
    logic        full;
    logic [4:0]  count;
    logic [31:0] dbg;
    logic        dbg_known;
  } rec_t;

  rec_t        rec_q[$];
  logic [31:0] fetch_q[$];

  logic [7:0]  m_mem[CELLS];
  bit          m_known[CELLS];
  int          m_mode = 0;     // 0 idle, 1 load, 2 flush
  int          m_ptr = 0;
  logic [7:0]  m_held[$];
  int          m_count = 0;
  bit          m_full = 0;
  logic [31:0] m_inst = '0;
  bit          m_err = 0;

  function automatic int m_idx(input logic [31:0] a, input int k);
    return int'((a + 32'(k)) % 32'(CELLS));
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [31:0] w = '0;
    for (int k = 0; k < BPI; k++) w = {w[23:0], m_mem[m_idx(a, k)]};
    return w;
  endfunction

  function automatic bit m_all_known(input logic [31:0] a);
    bit ok = 1;
    for (int k = 0; k < BPI; k++) ok = ok && m_known[m_idx(a, k)];
    return ok;
  endfunction

  // Writes held bytes at the pointer, zero-filling the remainder of the word.
  function automatic void m_write();
    for (int k = 0; k < BPI; k++) begin
      m_mem[m_idx(32'(m_ptr), k)]   = (k < m_held.size()) ? m_held[k] : 8'h00;
      m_known[m_idx(32'(m_ptr), k)] = 1;
    end
  endfunction

  function automatic void model_step();
    rec_t        r;
    logic [31:0] e;
    bit          err;
    r.dbg       = m_word(i_dbg_addr);
    r.dbg_known = m_all_known(i_dbg_addr);
    r.valid     = 0;
    if (m_mode == 0) begin
      if (i_step) begin
        e   = m_word(i_addr);
        err = 0;
`ifdef INST_MEM_FETCH_ERR_EN
        err = (i_addr % BPI != 0) || (i_addr >= CELLS);
        if (err) e = '0;
`endif
        m_inst  = e;
        m_err   = err;
        r.valid = 1;
        fetch_q.push_back(e);
      end
      if (i_ld_start) begin
        m_mode = 1; m_ptr = 0; m_held.delete(); m_count = 0; m_full = 0;
      end
    end else if (m_mode == 1) begin
      if (i_ld_valid && !m_full) begin
        m_held.push_back(i_ld_byte);
        if (m_held.size() == BPI) begin
          m_write();
          m_ptr   += BPI;
          m_count += BPI;
          m_held.delete();
          if (m_ptr == CELLS) begin
            m_full = 1;
            m_mode = 0;
          end
        end
      end
      if (i_ld_end && m_mode == 1) m_mode = (m_held.size() == 0) ? 0 : 2;
    end else begin
      m_write();
      m_count += m_held.size();
      m_held.delete();
      m_mode = 0;
    end
    r.inst  = m_inst;
    r.err   = m_err;
    r.ready = (m_mode == 1) && !m_full;
    r.busy  = (m_mode != 0);
    r.full  = m_full;
    r.count = 5'(m_count);
    rec_q.push_back(r);
  endfunction

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(posedge clk) begin
    rec_t r;
    #1;
    if (rec_q.size() > 0) begin
      r = rec_q.pop_front();
      chk("inst", o_inst, r.inst);
      chk("inst_valid", 32'(o_inst_valid), 32'(r.valid));
      chk("ld_ready", 32'(o_ld_ready), 32'(r.ready));
      chk("ld_busy", 32'(o_ld_busy), 32'(r.busy));
      chk("ld_full", 32'(o_ld_full), 32'(r.full));
      chk("ld_count", 32'(o_ld_count), 32'(r.count));
      if (r.dbg_known) chk("dbg_data", o_dbg_data, r.dbg);
`ifdef INST_MEM_FETCH_ERR_EN
      chk("fetch_err", 32'(o_fetch_err), 32'(r.err));
`endif
    end
    if (o_inst_valid) begin
      if (fetch_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL fetch_unexpected: got valid with word %h, required no fetch", o_inst);
      end else begin
        chk("fetch_word", o_inst, fetch_q.pop_front());
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic drive(input bit st, input bit en, input bit vl,
                       input logic [7:0] b, input bit sp,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    i_ld_start = st; i_ld_end = en; i_ld_valid = vl; i_ld_byte = b;
    i_step = sp; i_addr = a; i_dbg_addr = d;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 8'h00, 0, 32'h0, 32'($urandom_range(0, 15)));
  endtask

  task automatic fetch(input logic [31:0] a);
    drive(0, 0, 0, 8'h00, 1, a, a);
    drive(0, 0, 0, 8'h00, 0, a, a);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_inst"}, o_inst, 32'h0);
    chk({tag, "_valid"}, 32'(o_inst_valid), 32'h0);
    chk({tag, "_ready"}, 32'(o_ld_ready), 32'h0);
    chk({tag, "_busy"}, 32'(o_ld_busy), 32'h0);
    chk({tag, "_full"}, 32'(o_ld_full), 32'h0);
    chk({tag, "_count"}, 32'(o_ld_count), 32'h0);
    chk({tag, "_dbg"}, o_dbg_data, 32'h0);
`ifdef INST_MEM_FETCH_ERR_EN
    chk({tag, "_err"}, 32'(o_fetch_err), 32'h0);
`endif
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 15));
      1: return 32'($urandom_range(0, 3) * 4);
      2: return 32'd14;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;

    // Overfill: 20 bytes into 16 cells; bytes 17..20 must be dropped
    drive(1, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 8'($urandom), 0, 0, 32'($urandom_range(0, 15)));
    idle(2);

    // 01..08 then end in a separate cycle: no flush
    drive(1, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 1; i <= 8; i++) drive(0, 0, 1, 8'(i), 0, 0, 4);
    drive(0, 1, 0, 8'h00, 0, 0, 4);
    idle(1);
    fetch(0);
    fetch(4);

    // AA..EE then end: one-cycle flush, word at 4 becomes EE000000
    drive(1, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'(8'hAA + 8'(i * 17)), 0, 0, 4);
    drive(0, 1, 0, 8'h00, 0, 0, 4);
    idle(1);
    fetch(4);
    fetch(14);
    fetch(0);

    // Step held high during a load; debug read aimed at the word being written
    drive(1, 0, 0, 8'h00, 1, 8, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 8'($urandom), 1, 8, 0);
    drive(0, 1, 1, 8'($urandom), 1, 8, 4);
    idle(2);

    // Reset two bytes into a word
    drive(1, 0, 0, 8'h00, 0, 0, 0);
    drive(0, 0, 1, 8'h5A, 0, 0, 0);
    drive(0, 0, 1, 8'hA5, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    i_ld_start = 0; i_ld_end = 0; i_ld_valid = 0; i_step = 0;
    #1;
    check_reset_values("mid_rst");
    m_mode = 0; m_ptr = 0; m_held.delete(); m_count = 0; m_full = 0;
    m_inst = '0; m_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 8'(8'h10 + 8'(i)), 0, 0, 0);
    drive(0, 1, 0, 8'h00, 0, 0, 0);
    fetch(0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
            pick_addr(), pick_addr());
    end
    drive(0, 1, 0, 8'h00, 0, 0, 0);
    idle(4);

    @(posedge clk);
    #2;
    chk("rec_q_drained", 32'(rec_q.size()), 32'h0);
    chk("fetch_q_drained", 32'(fetch_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
